mem_initiator: RTL and testbench

//  Bus master that drives MainMemory on behalf of the cache controller.

---
 rtl/mem_initiator_pkg.sv | 28 ++
 rtl/mem_initiator_rd_valid_pipe.sv | 36 +++
 rtl/mem_initiator.sv | 173 +++++++++++++++++
 tb/tb_mem_initiator.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared address/data/MESI types and the initiator FSM state set.
`timescale 1ns/1ps
package mem_initiator_pkg;

    typedef struct packed {
        logic [7:0] Page_reference;
        logic [7:0] Address_code;
    } Taddress;

    typedef logic [63:0] Tdata_sb;

    typedef enum logic [1:0] {INV, SHR, EXC, MOD} Tmesi_state;

    typedef enum logic [1:0] {IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN} Tinit_state;

    localparam int INIT_MAX_LINE_WORDS = 16;
    localparam int INIT_BEAT_W = $clog2(INIT_MAX_LINE_WORDS);

    // Offset stays inside the page; Address_code wraps at its own width.
    function automatic Taddress beat_addr(input Taddress base,
                                          input logic [INIT_BEAT_W-1:0] k);
        Taddress a;
        a = base;
        a.Address_code = base.Address_code + 8'(k);
        return a;
    endfunction

endpackage

// File: rtl/mem_initiator_rd_valid_pipe.sv
// Read-valid delay line: tracks in-flight read beats and tags the last one.
`timescale 1ns/1ps
module mem_rd_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last,
    output logic o_busy
);

    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_l;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v <= '0;
            r_l <= '0;
        end else begin
            r_v[0] <= i_valid;
            r_l[0] <= i_valid & i_last;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k] <= r_v[k-1];
                r_l[k] <= r_l[k-1];
            end
        end
    end

    assign o_valid = r_v[DEPTH-1];
    assign o_last  = r_l[DEPTH-1];
    assign o_busy  = |r_v;

endmodule

// File: rtl/mem_initiator.sv
// MainMemory bus master: sequences single/line read and write requests
// from the cache controller onto the memory port.
`timescale 1ns/1ps
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int LINE_WORDS   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_burst,
    input  Taddress    req_addr,
    input  Tmesi_state req_mesi,
    input  logic       wdat_valid,
    output logic       wdat_ready,
    input  Tdata_sb    wdat_data,
    output logic       rsp_valid,
    output Tdata_sb    rsp_data,
    output Tmesi_state rsp_mesi,
    output logic       rsp_last,
    output logic       wr_done,
    output Taddress    mem_addr,
    output Tdata_sb    mem_wdata,
    output logic       mem_we,
    output Tmesi_state mem_mesi_out,
    input  Tdata_sb    mem_rdata,
    input  Tmesi_state mem_mesi_in
);

    localparam int BW = INIT_BEAT_W;
    localparam logic [BW-1:0] LAST_BURST = BW'(LINE_WORDS - 1);

    Tinit_state r_state, w_next;

    logic          r_req_ready, r_wdat_ready;
    logic          r_burst;
    Taddress       r_req_addr;
    Tmesi_state    r_req_mesi;
    logic [BW-1:0] r_beat, w_beat_n;
    logic          r_mem_we, w_mem_we;
    Taddress       r_mem_addr, w_mem_addr;
    Tdata_sb       r_mem_wdata, w_mem_wdata;
    Tmesi_state    r_mem_mesi, w_mem_mesi;
    logic          r_rd_iss, w_rd_iss;
    logic          r_rd_last, w_rd_last;
    logic          r_wr_done, w_wr_done;
    logic          r_rsp_valid, r_rsp_last;
    Tdata_sb       r_rsp_data;
    Tmesi_state    r_rsp_mesi;

    logic          w_accept, w_wbeat, w_at_last;
    logic          w_pv, w_pl, w_pbusy;

    assign w_accept  = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_wbeat   = (r_state == WR_BEAT) && r_wdat_ready && wdat_valid;
    assign w_at_last = (r_beat == (r_burst ? LAST_BURST : '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_accept) w_next = req_write ? WR_BEAT : RD_ISSUE;
            WR_BEAT:  if (w_wbeat && w_at_last) w_next = IDLE;
            RD_ISSUE: if (w_at_last) w_next = RD_DRAIN;
            RD_DRAIN: if (!r_rd_iss && !w_pbusy) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_beat_n    = r_beat;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_mesi  = r_mem_mesi;
        w_rd_iss    = 1'b0;
        w_rd_last   = 1'b0;
        w_wr_done   = 1'b0;
        if (w_accept) w_beat_n = '0;
        if (w_wbeat) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = beat_addr(r_req_addr, r_beat);
            w_mem_wdata = wdat_data;
            w_mem_mesi  = r_req_mesi;
            w_wr_done   = w_at_last;
            w_beat_n    = r_beat + 1'b1;
        end
        if (r_state == RD_ISSUE) begin
            w_mem_addr = beat_addr(r_req_addr, r_beat);
            w_rd_iss   = 1'b1;
            w_rd_last  = w_at_last;
            w_beat_n   = r_beat + 1'b1;
        end
    end

    // r_rd_iss marks the cycle mem_addr carries a read; the pipe ages it.
    mem_rd_valid_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_rd_iss),
        .i_last  (r_rd_last),
        .o_valid (w_pv),
        .o_last  (w_pl),
        .o_busy  (w_pbusy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_ready  <= 1'b0;
            r_wdat_ready <= 1'b0;
            r_burst      <= 1'b0;
            r_req_addr   <= '0;
            r_req_mesi   <= INV;
            r_beat       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_mesi   <= INV;
            r_rd_iss     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_mesi   <= INV;
        end else begin
            r_req_ready  <= (w_next == IDLE);
            r_wdat_ready <= (w_next == WR_BEAT);
            if (w_accept) begin
                r_burst    <= req_burst;
                r_req_addr <= req_addr;
                r_req_mesi <= req_mesi;
            end
            r_beat      <= w_beat_n;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_mesi  <= w_mem_mesi;
            r_rd_iss    <= w_rd_iss;
            r_rd_last   <= w_rd_last;
            r_wr_done   <= w_wr_done;
            r_rsp_valid <= w_pv;
            r_rsp_last  <= w_pv & w_pl;
            if (w_pv) begin
                r_rsp_data <= mem_rdata;
                r_rsp_mesi <= mem_mesi_in;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign wdat_ready   = r_wdat_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_mesi     = r_rsp_mesi;
    assign rsp_last     = r_rsp_last;
    assign wr_done      = r_wr_done;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = r_mem_we;
    assign mem_mesi_out = r_mem_mesi;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed table, hand corner sequences and
// random traffic checked against a word-level memory model.
`timescale 1ns/1ps
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic       req_burst = 1'b0;
    Taddress    req_addr = '0;
    Tmesi_state req_mesi = INV;
    logic       wdat_valid = 1'b0;
    logic       wdat_ready;
    Tdata_sb    wdat_data = '0;
    logic       rsp_valid;
    Tdata_sb    rsp_data;
    Tmesi_state rsp_mesi;
    logic       rsp_last;
    logic       wr_done;
    Taddress    mem_addr;
    Tdata_sb    mem_wdata;
    logic       mem_we;
    Tmesi_state mem_mesi_out;
    Tdata_sb    mem_rdata;
    Tmesi_state mem_mesi_in;

    always #5 clk = ~clk;

    mem_initiator #(.LINE_WORDS(LW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_burst(req_burst),
        .req_addr(req_addr), .req_mesi(req_mesi),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
        .wdat_data(wdat_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_mesi(rsp_mesi), .rsp_last(rsp_last),
        .wr_done(wr_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_mesi_out(mem_mesi_out),
        .mem_rdata(mem_rdata), .mem_mesi_in(mem_mesi_in)
    );

    function automatic Tdata_sb init_val(input logic [15:0] a);
        return {16'hA5A5, 16'h5A5A, 16'h0000, a};
    endfunction

    // MainMemory stand-in, 1-cycle read; stored as delta from the preset pattern
    bit [63:0]   bdelta [0:65535];
    bit [1:0]    bmd    [0:65535];
    logic [15:0] ma;
    assign ma = mem_addr;
    always @(posedge clk) begin
        mem_rdata   <= init_val(ma) ^ bdelta[ma];
        mem_mesi_in <= Tmesi_state'(bmd[ma] ^ 2'(SHR));
        if (mem_we) begin
            bdelta[ma] <= mem_wdata ^ init_val(ma);
            bmd[ma]    <= 2'(mem_mesi_out) ^ 2'(SHR);
        end
    end

    // Reference model: word-addressed memory contents
    Tdata_sb    mdat  [logic [15:0]];
    Tmesi_state mmesi [logic [15:0]];

    function automatic Tdata_sb model_d(input logic [15:0] a);
        return mdat.exists(a) ? mdat[a] : init_val(a);
    endfunction
    function automatic Tmesi_state model_m(input logic [15:0] a);
        return mmesi.exists(a) ? mmesi[a] : SHR;
    endfunction
    function automatic Taddress nth(input Taddress a, input int k);
        Taddress r;
        r.Page_reference = a.Page_reference;
        r.Address_code   = 8'((int'(a.Address_code) + k) % 256);
        return r;
    endfunction

    typedef struct packed {
        Taddress    a;
        Tdata_sb    d;
        Tmesi_state m;
    } wexp_t;
    typedef struct packed {
        Tdata_sb    d;
        Tmesi_state m;
        logic       last;
    } rexp_t;

    wexp_t ew[$];
    rexp_t er[$];
    int    we_cyc[$];
    int    rsp_cyc[$];

    int n_checks = 0, n_errs = 0;
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, rsp_at_acc = 0;
    int rsp_cnt = 0, rl_cnt = 0, wd_cnt = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wexp_t w;
        rexp_t r;
        if (mem_we) begin
            we_cyc.push_back(cyc);
            if (ew.size() == 0) check("unexpected_we", 1, 0);
            else begin
                w = ew.pop_front();
                check("mem_write", {mem_addr, mem_wdata, mem_mesi_out}, w);
            end
        end
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            rsp_cnt++;
            if (rsp_last) rl_cnt++;
            if (er.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
                r = er.pop_front();
                check("rsp_beat", {rsp_data, rsp_mesi, rsp_last}, r);
            end
        end
        if (wr_done) wd_cnt++;
    endtask

    // One clock: handshakes visible at the negedge land on the next posedge.
    task automatic tick();
        logic pend;
        pend = req_valid && req_ready && !reset;
        @(posedge clk);
        cyc++;
        if (pend) begin
            acc_cnt++;
            acc_cyc = cyc;
            rsp_at_acc = rsp_cnt;
        end
        @(negedge clk);
        if (!reset) monitor();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check(name, req_ready, 1);
    endtask

    task automatic run_txn(input logic wr, input logic burst,
                           input Taddress a, input Tmesi_state m,
                           input Tdata_sb base, input int stall_n,
                           input bit rnd);
        int nb, s, n;
        Taddress ak;
        nb = burst ? LW : 1;
        wait_ready("ready_before");
        if (!wr)
            for (int k = 0; k < nb; k++) begin
                ak = nth(a, k);
                er.push_back('{model_d(ak), model_m(ak), (k == nb - 1)});
            end
        req_valid = 1'b1;
        req_write = wr;
        req_burst = burst;
        req_addr  = a;
        req_mesi  = m;
        tick();
        req_valid = 1'b0;
        if (wr) begin
            for (int k = 0; k < nb; k++) begin
                s = rnd ? int'($urandom_range(0, 2)) : (k == 1 ? stall_n : 0);
                wdat_valid = 1'b0;
                for (int i = 0; i < s; i++) tick();
                n = 0;
                while (!wdat_ready && n < 50) begin
                    tick();
                    n++;
                end
                check("wdat_ready", wdat_ready, 1);
                ak = nth(a, k);
                ew.push_back('{ak, base + 64'(k), m});
                mdat[ak]  = base + 64'(k);
                mmesi[ak] = m;
                wdat_valid = 1'b1;
                wdat_data  = base + 64'(k);
                tick();
            end
            wdat_valid = 1'b0;
        end
        wait_ready("ready_after");
        check("drain_w", ew.size(), 0);
        check("drain_r", er.size(), 0);
    endtask

    typedef struct {
        logic       wr;
        logic       burst;
        logic [7:0] pg;
        logic [7:0] code;
        Tmesi_state m;
        Tdata_sb    base;
        int         stall_n;
        logic [7:0] exp_last_code;
        int         exp_beats;
        int         exp_gap;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[6];
        int      wd0, rl0, rs0, a0, n;
        Taddress a;

        tbl[0] = '{1, 0, 8'h00, 8'h10, EXC, 64'hDEADBEEF_01234567, 0, 8'h10, 1, 0};
        tbl[1] = '{0, 0, 8'h00, 8'h10, INV, 64'h0, 0, 8'h10, 1, 0};
        tbl[2] = '{1, 1, 8'h01, 8'hFE, SHR, 64'h1111_2222_3333_0000, 3, 8'h01, 4, 4};
        tbl[3] = '{0, 1, 8'h01, 8'hFE, INV, 64'h0, 0, 8'h01, 4, 1};
        tbl[4] = '{1, 1, 8'h03, 8'h7C, MOD, 64'hCAFE_F00D_0000_0100, 0, 8'h7F, 4, 1};
        tbl[5] = '{0, 0, 8'h03, 8'h7E, INV, 64'h0, 0, 8'h7E, 1, 0};

        // reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_wdat_ready", wdat_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_mesi", mem_mesi_out, INV);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_mesi", rsp_mesi, INV);
        reset = 1'b0;
        #1 check("ready_at_release", req_ready, 0);
        tick();
        check("ready_one_cycle_after", req_ready, 1);

        // directed table
        for (int i = 0; i < 6; i++) begin
            a.Page_reference = tbl[i].pg;
            a.Address_code   = tbl[i].code;
            wd0 = wd_cnt;
            rl0 = rl_cnt;
            we_cyc.delete();
            rsp_cyc.delete();
            run_txn(tbl[i].wr, tbl[i].burst, a, tbl[i].m, tbl[i].base,
                    tbl[i].stall_n, 0);
            check("last_addr", mem_addr, {tbl[i].pg, tbl[i].exp_last_code});
            if (tbl[i].wr) begin
                check("we_beats", we_cyc.size(), tbl[i].exp_beats);
                check("wr_done_cnt", wd_cnt - wd0, 1);
                if (tbl[i].burst) begin
                    if (we_cyc.size() >= 2)
                        check("we_gap", we_cyc[1] - we_cyc[0], tbl[i].exp_gap);
                    else
                        check("we_gap_n", we_cyc.size(), 2);
                end
            end else begin
                check("rsp_beats", rsp_cyc.size(), tbl[i].exp_beats);
                check("rsp_last_cnt", rl_cnt - rl0, 1);
                if (rsp_cyc.size() > 0) begin
                    check("rsp_latency", rsp_cyc[0] - acc_cyc, 3);
                    check("rsp_consec", rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[0],
                          tbl[i].exp_beats - 1);
                end
            end
        end

        // back-to-back reads with req_valid held high
        wait_ready("ready_b2b");
        a = '{8'h00, 8'h10};
        er.push_back('{model_d(a), model_m(a), 1'b1});
        er.push_back('{model_d(a), model_m(a), 1'b1});
        rs0 = rsp_cnt;
        a0  = acc_cnt;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_burst = 1'b0;
        req_addr  = a;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 100) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_cnt - a0, 2);
        check("b2b_no_overlap", rsp_at_acc - rs0, 1);
        wait_ready("ready_b2b_end");
        check("b2b_rsp_cnt", rsp_cnt - rs0, 2);
        check("b2b_drain", er.size(), 0);

        // reset during beat 2 of a burst write
        wd0 = wd_cnt;
        a = '{8'h02, 8'h40};
        wait_ready("ready_rstwr");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_burst = 1'b1;
        req_addr  = a;
        req_mesi  = MOD;
        tick();
        req_valid = 1'b0;
        ew.push_back('{a, 64'h7777_0000_0000_0001, MOD});
        mdat[a]  = 64'h7777_0000_0000_0001;
        mmesi[a] = MOD;
        wdat_valid = 1'b1;
        wdat_data  = 64'h7777_0000_0000_0001;
        tick();
        wdat_data  = 64'h7777_0000_0000_0002;
        @(posedge clk);
        cyc++;
        #1 reset = 1'b1;
        #1 check("rst_we_now", mem_we, 0);
        check("rst_no_done", wr_done, 0);
        wdat_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check("rst_wr_done_cnt", wd_cnt - wd0, 0);
        check("rst_ew_empty", ew.size(), 0);
        check("rst_loc2", bdelta[16'h0241], 0);
        check("rst_loc3", bdelta[16'h0242], 0);
        check("rst_loc4", bdelta[16'h0243], 0);
        run_txn(0, 1, a, INV, 0, 0, 0);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            a.Page_reference = 8'($urandom_range(0, 3));
            a.Address_code   = $urandom_range(0, 1) ? 8'(8'hFC + $urandom_range(0, 3))
                                                    : 8'($urandom_range(0, 255));
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                    Tmesi_state'($urandom_range(0, 3)),
                    {$urandom, $urandom}, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
